// File: rtl/interconnect_link_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_link_buffer_pkg
// Description : Shared interconnect link definitions. Provides the physical
//               plane count, the tag and word widths, the {tag, data} packet
//               type, and a helper that sizes the per-plane occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
package interconnect_link_buffer_pkg;

  localparam int TIA_NUM_PHYSICAL_PLANES = 4;
  localparam int TIA_TAG_WIDTH           = 4;
  localparam int TIA_WORD_WIDTH          = 32;

  typedef struct packed {
    logic [TIA_TAG_WIDTH-1:0]  tag;
    logic [TIA_WORD_WIDTH-1:0] data;
  } interconnect_packet_t;

  // The counter must hold every value 0..depth inclusive.
  function automatic int interconnect_buffer_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/interconnect_link_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_link_if
// Description : Interconnect link bundle. One req/ack pair plus tag and data
//               lines per physical plane.
//               sender   : drives reqs, tag_lines, data_lines; samples acks
//               receiver : samples reqs, tag_lines, data_lines; drives acks
// Revision    : 1.0 - initial release
// ============================================================================
interface interconnect_link_if;
  import interconnect_link_buffer_pkg::*;

  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     reqs;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     acks;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_TAG_WIDTH-1:0]  tag_lines;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_WORD_WIDTH-1:0] data_lines;

  modport sender   (output reqs, output tag_lines, output data_lines, input  acks);
  modport receiver (input  reqs, input  tag_lines, input  data_lines, output acks);

endinterface
`default_nettype wire

// File: rtl/interconnect_link_buffer_plane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_plane_fifo
// Description : Elastic FIFO for one physical plane of the interconnect link.
//               Ports:
//                 clk, rst_n              clock, async active-low reset
//                 i_push_req/o_push_ack   upstream handshake, i_push_pkt data
//                 o_pop_req/i_pop_ack     downstream handshake, o_pop_pkt data
//                 o_count                 registered occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module interconnect_plane_fifo
  import interconnect_link_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              i_push_req,
  output logic                                              o_push_ack,
  input  interconnect_packet_t                              i_push_pkt,
  output logic                                              o_pop_req,
  input  logic                                              i_pop_ack,
  output interconnect_packet_t                              o_pop_pkt,
  output logic [interconnect_buffer_count_width(DEPTH)-1:0] o_count
);

  localparam int C_CNT_W = interconnect_buffer_count_width(DEPTH);
  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
  localparam logic [C_PTR_W-1:0] C_LAST_IDX  = C_PTR_W'(DEPTH - 1);

  interconnect_packet_t r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wptr;
  logic [C_PTR_W-1:0]   r_rptr;
  logic [C_CNT_W-1:0]   r_count;

  logic w_push;
  logic w_pop;

  // DEPTH need not be a power of two, so the wrap is an explicit compare
  // against the last slot rather than relying on pointer overflow.
  function automatic logic [C_PTR_W-1:0] f_next_ptr(input logic [C_PTR_W-1:0] ptr);
    if (ptr == C_LAST_IDX) begin
      return '0;
    end
    return ptr + C_PTR_W'(1);
  endfunction

  // Both handshake outputs depend only on the registered count (and reset),
  // so neither side's timing reaches across the buffer.
  assign o_push_ack = rst_n && (r_count != C_DEPTH_CNT);
  assign o_pop_req  = (r_count != '0);
  assign o_pop_pkt  = r_mem[r_rptr];
  assign o_count    = r_count;

  assign w_push = i_push_req && o_push_ack;
  assign w_pop  = i_pop_ack && o_pop_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_pkt;
        r_wptr        <= f_next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next_ptr(r_rptr);
      end
      // A push is impossible when full and a pop impossible when empty,
      // so the count stays inside 0..DEPTH without extra guarding.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/interconnect_link_buffer.sv
`default_nettype none
// ============================================================================
// Module      : interconnect_link_buffer
// Description : Per-plane elastic buffer on an interconnect link bundle. Each
//               physical plane gets an independent FIFO of DEPTH packets.
//               Ports:
//                 clock, reset_n            clock, async active-low reset
//                 input_interconnect_link   upstream bundle (receiver side)
//                 output_interconnect_link  downstream bundle (sender side)
//                 plane_counts              registered occupancy per plane
//               DEPTH legal range is 1..16.
// Revision    : 1.0 - initial release
// ============================================================================
module interconnect_link_buffer
  import interconnect_link_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  interconnect_link_if.receiver        input_interconnect_link,
  interconnect_link_if.sender          output_interconnect_link,
  output logic [TIA_NUM_PHYSICAL_PLANES-1:0][interconnect_buffer_count_width(DEPTH)-1:0] plane_counts
);

  localparam int C_CNT_W = interconnect_buffer_count_width(DEPTH);

  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     w_push_ack;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     w_pop_req;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_TAG_WIDTH-1:0]  w_pop_tag;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_WORD_WIDTH-1:0] w_pop_data;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][C_CNT_W-1:0]        w_count;

  generate
    for (genvar p = 0; p < TIA_NUM_PHYSICAL_PLANES; p++) begin : g_plane
      interconnect_packet_t w_in_pkt;
      interconnect_packet_t w_out_pkt;

      assign w_in_pkt.tag  = input_interconnect_link.tag_lines[p];
      assign w_in_pkt.data = input_interconnect_link.data_lines[p];

      interconnect_plane_fifo #(
        .DEPTH (DEPTH)
      ) u_plane_fifo (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_push_req (input_interconnect_link.reqs[p]),
        .o_push_ack (w_push_ack[p]),
        .i_push_pkt (w_in_pkt),
        .o_pop_req  (w_pop_req[p]),
        .i_pop_ack  (output_interconnect_link.acks[p]),
        .o_pop_pkt  (w_out_pkt),
        .o_count    (w_count[p])
      );

      assign w_pop_tag[p]  = w_out_pkt.tag;
      assign w_pop_data[p] = w_out_pkt.data;
    end
  endgenerate

  assign input_interconnect_link.acks        = w_push_ack;
  assign output_interconnect_link.reqs       = w_pop_req;
  assign output_interconnect_link.tag_lines  = w_pop_tag;
  assign output_interconnect_link.data_lines = w_pop_data;
  assign plane_counts                        = w_count;

endmodule
`default_nettype wire

// File: tb/tb_interconnect_link_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_interconnect_link_buffer
// Description : Self-checking bench for interconnect_link_buffer. Two
//               instances (DEPTH=2 and DEPTH=3) share clock and reset; each
//               is compared against a queue-per-plane reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interconnect_link_buffer;
  import interconnect_link_buffer_pkg::*;

  localparam int NP = TIA_NUM_PHYSICAL_PLANES;
  localparam int TW = TIA_TAG_WIDTH;
  localparam int WW = TIA_WORD_WIDTH;
  localparam int CW = interconnect_buffer_count_width(3);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  interconnect_link_if in_if0 ();
  interconnect_link_if out_if0 ();
  interconnect_link_if in_if1 ();
  interconnect_link_if out_if1 ();

  logic [NP-1:0]          drv_req  [2];
  logic [NP-1:0][TW-1:0]  drv_tag  [2];
  logic [NP-1:0][WW-1:0]  drv_data [2];
  logic [NP-1:0]          drv_ack  [2];

  logic [NP-1:0]          obs_ack  [2];
  logic [NP-1:0]          obs_req  [2];
  logic [NP-1:0][TW-1:0]  obs_tag  [2];
  logic [NP-1:0][WW-1:0]  obs_data [2];
  logic [NP-1:0][CW-1:0]  obs_cnt  [2];
  logic [NP-1:0][CW-1:0]  cnt0;
  logic [NP-1:0][CW-1:0]  cnt1;

  assign in_if0.reqs       = drv_req[0];
  assign in_if0.tag_lines  = drv_tag[0];
  assign in_if0.data_lines = drv_data[0];
  assign out_if0.acks      = drv_ack[0];
  assign in_if1.reqs       = drv_req[1];
  assign in_if1.tag_lines  = drv_tag[1];
  assign in_if1.data_lines = drv_data[1];
  assign out_if1.acks      = drv_ack[1];

  assign obs_ack[0]  = in_if0.acks;
  assign obs_req[0]  = out_if0.reqs;
  assign obs_tag[0]  = out_if0.tag_lines;
  assign obs_data[0] = out_if0.data_lines;
  assign obs_cnt[0]  = cnt0;
  assign obs_ack[1]  = in_if1.acks;
  assign obs_req[1]  = out_if1.reqs;
  assign obs_tag[1]  = out_if1.tag_lines;
  assign obs_data[1] = out_if1.data_lines;
  assign obs_cnt[1]  = cnt1;

  interconnect_link_buffer #(.DEPTH(2)) u_dut_d2 (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .input_interconnect_link  (in_if0),
    .output_interconnect_link (out_if0),
    .plane_counts             (cnt0)
  );

  interconnect_link_buffer #(.DEPTH(3)) u_dut_d3 (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .input_interconnect_link  (in_if1),
    .output_interconnect_link (out_if1),
    .plane_counts             (cnt1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per instance and plane, capacity = depth.
  interconnect_packet_t mq [2][NP][$];
  int  pushes    [2][NP];
  int  pops      [2][NP];
  int  offered   [2][NP];
  bit  last_push [2][NP];

  function automatic int depth_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_drive();
    for (int d = 0; d < 2; d++) begin
      drv_req[d]  = '0;
      drv_tag[d]  = '0;
      drv_data[d] = '0;
      drv_ack[d]  = '0;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        mq[d][p].delete();
        pushes[d][p]    = 0;
        pops[d][p]      = 0;
        offered[d][p]   = 0;
        last_push[d][p] = 1'b0;
      end
    end
  endtask

  // Leaves the bench 1 ns after a rising edge with the link idle.
  task automatic do_reset();
    clear_drive();
    model_clear();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic compare_model();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        int sz;
        sz = mq[d][p].size();
        check($sformatf("d%0d_p%0d_in_ack", d, p), 64'(obs_ack[d][p]), 64'(sz < depth_of(d)));
        check($sformatf("d%0d_p%0d_out_req", d, p), 64'(obs_req[d][p]), 64'(sz > 0));
        check($sformatf("d%0d_p%0d_count", d, p), 64'(obs_cnt[d][p]), 64'(sz));
        if (sz > 0) begin
          check($sformatf("d%0d_p%0d_pkt", d, p),
                64'({obs_tag[d][p], obs_data[d][p]}),
                64'({mq[d][p][0].tag, mq[d][p][0].data}));
        end
      end
    end
  endtask

  // mode 0: random req/ack; 1: stream 100 packets, ack high;
  // 2: plane 0 stalled, others stream; 3: drain.
  task automatic cycle(input int mode);
    bit pu [2][NP];
    bit po [2][NP];
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        bit want;
        bit ack;
        if (!(drv_req[d][p] && !last_push[d][p])) begin
          case (mode)
            0:       want = ($urandom_range(0, 99) < 70);
            1:       want = (offered[d][p] < 100);
            2:       want = 1'b1;
            default: want = 1'b0;
          endcase
          drv_req[d][p] = want;
          if (want) begin
            drv_tag[d][p]  = TW'($urandom);
            drv_data[d][p] = $urandom;
            offered[d][p]++;
          end
        end
        case (mode)
          0:       ack = 1'($urandom_range(0, 1));
          2:       ack = (p != 0);
          default: ack = 1'b1;
        endcase
        drv_ack[d][p] = ack;
      end
    end
    compare_model();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        pu[d][p] = drv_req[d][p] && (mq[d][p].size() < depth_of(d));
        po[d][p] = drv_ack[d][p] && (mq[d][p].size() > 0);
      end
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        if (po[d][p]) begin
          void'(mq[d][p].pop_front());
          pops[d][p]++;
        end
        if (pu[d][p]) begin
          interconnect_packet_t pk;
          pk.tag  = drv_tag[d][p];
          pk.data = drv_data[d][p];
          mq[d][p].push_back(pk);
          pushes[d][p]++;
        end
        last_push[d][p] = pu[d][p];
      end
    end
    #1;
  endtask

  typedef struct {
    int            plane;
    bit            in_req;
    logic [TW-1:0] tag;
    logic [WW-1:0] data;
    bit            out_ack;
    int            exp_cnt;
    bit            exp_in_ack;
    bit            exp_out_req;
    logic [TW-1:0] exp_tag;
    logic [WW-1:0] exp_data;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected state after each edge on the DEPTH=2 instance.
    vt[0] = '{0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 1, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF};
    vt[1] = '{0, 1'b0, 4'd0, 32'h0,        1'b1, 0, 1'b1, 1'b0, 4'd0, 32'h0};
    vt[2] = '{1, 1'b1, 4'd1, 32'h101,      1'b0, 1, 1'b1, 1'b1, 4'd1, 32'h101};
    vt[3] = '{1, 1'b1, 4'd2, 32'h102,      1'b0, 2, 1'b0, 1'b1, 4'd1, 32'h101};
    vt[4] = '{1, 1'b1, 4'd3, 32'h103,      1'b0, 2, 1'b0, 1'b1, 4'd1, 32'h101};
    vt[5] = '{1, 1'b1, 4'd3, 32'h103,      1'b1, 1, 1'b1, 1'b1, 4'd2, 32'h102};
    vt[6] = '{1, 1'b1, 4'd3, 32'h103,      1'b1, 1, 1'b1, 1'b1, 4'd3, 32'h103};
    vt[7] = '{1, 1'b0, 4'd0, 32'h0,        1'b1, 0, 1'b1, 1'b0, 4'd0, 32'h0};

    clear_drive();
    model_clear();
    #12;
    check("in_reset_acks", 64'(obs_ack[0]), 64'(0));
    do_reset();

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_d%0d_acks", d), 64'(obs_ack[d]), 64'({NP{1'b1}}));
      check($sformatf("rst_d%0d_reqs", d), 64'(obs_req[d]), 64'(0));
      check($sformatf("rst_d%0d_counts", d), 64'(obs_cnt[d]), 64'(0));
      check($sformatf("rst_d%0d_data", d), 64'(obs_data[d]), 64'(0));
    end

    // Table-driven single packet and backpressure sequences
    for (int i = 0; i < 8; i++) begin
      clear_drive();
      drv_req[0][vt[i].plane]  = vt[i].in_req;
      drv_tag[0][vt[i].plane]  = vt[i].tag;
      drv_data[0][vt[i].plane] = vt[i].data;
      drv_ack[0][vt[i].plane]  = vt[i].out_ack;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_count", i), 64'(obs_cnt[0][vt[i].plane]), 64'(vt[i].exp_cnt));
      check($sformatf("vec%0d_in_ack", i), 64'(obs_ack[0][vt[i].plane]), 64'(vt[i].exp_in_ack));
      check($sformatf("vec%0d_out_req", i), 64'(obs_req[0][vt[i].plane]), 64'(vt[i].exp_out_req));
      if (vt[i].exp_out_req) begin
        check($sformatf("vec%0d_pkt", i),
              64'({obs_tag[0][vt[i].plane], obs_data[0][vt[i].plane]}),
              64'({vt[i].exp_tag, vt[i].exp_data}));
      end
    end

    // Continuous streaming on every plane
    do_reset();
    repeat (101) cycle(1);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("stream_d%0d_p%0d_pops", d, p), 64'(pops[d][p]), 64'(100));
      end
    end

    // Plane 0 stalled and full while the others stream
    do_reset();
    repeat (50) cycle(2);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("iso_d%0d_p1_pops", d), 64'(pops[d][1]), 64'(49));
      check($sformatf("iso_d%0d_p0_count", d), 64'(obs_cnt[d][0]), 64'(depth_of(d)));
    end

    // Random traffic, then drain
    do_reset();
    repeat (300) cycle(0);
    repeat (10) cycle(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("drain_d%0d_counts", d), 64'(obs_cnt[d]), 64'(0));
      check($sformatf("drain_d%0d_reqs", d), 64'(obs_req[d]), 64'(0));
    end

    // Reset asserted mid-stream with plane 2 holding two packets
    do_reset();
    drv_req[0][2]  = 1'b1;
    drv_tag[0][2]  = 4'd5;
    drv_data[0][2] = 32'hAAAA0001;
    @(posedge clock);
    #1;
    drv_tag[0][2]  = 4'd6;
    drv_data[0][2] = 32'hAAAA0002;
    @(posedge clock);
    #1;
    check("mid_pre_count", 64'(obs_cnt[0][2]), 64'(2));
    drv_tag[0][2]  = 4'd7;
    drv_data[0][2] = 32'hAAAA0003;
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid_rst_d%0d_acks", d), 64'(obs_ack[d]), 64'(0));
      check($sformatf("mid_rst_d%0d_reqs", d), 64'(obs_req[d]), 64'(0));
      check($sformatf("mid_rst_d%0d_counts", d), 64'(obs_cnt[d]), 64'(0));
    end
    check("mid_rst_pkt", 64'({obs_tag[0][2], obs_data[0][2]}), 64'(0));
    clear_drive();
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    #1;
    check("rel_acks", 64'(obs_ack[0]), 64'({NP{1'b1}}));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("rel_no_stale_%0d", i), 64'(obs_req[0]), 64'(0));
    end
    drv_req[0][2]  = 1'b1;
    drv_tag[0][2]  = 4'd9;
    drv_data[0][2] = 32'h0000F00D;
    @(posedge clock);
    #1;
    drv_req[0][2] = 1'b0;
    check("rel_fresh_req", 64'(obs_req[0]), 64'(4'b0100));
    check("rel_fresh_pkt", 64'({obs_tag[0][2], obs_data[0][2]}), 64'({4'd9, 32'h0000F00D}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
